dma_bus_serv: RTL and testbench

- Byte-wide bus-slave memory that services the DMA master port of the SDIO host controller (sdio_top).
- Stores block data written by the controller during card reads and returns data on request during card writes.
- Sits on the bus_clk domain between the SDIO controller's bus interface and system memory; used as the system-memory stand-in in the SDIO subsystem.
- Synthesizable: internal single-port byte array, self-initialising after reset.

---
 rtl/dma_bus_serv.sv | 115 +++++++++++
 tb/tb_dma_bus_serv.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_serv.sv
// Byte-wide bus-slave memory for the SDIO host DMA port: fills itself with a
// seeded pattern after reset, then serves zero-latency writes and RD_LAT-cycle reads.
module dma_bus_serv #(
    parameter int         MEM_AW    = 12,
    parameter int         RD_LAT    = 2,
    parameter logic [7:0] INIT_SEED = 8'h00
) (
    input  logic        bus_clk,
    input  logic        rstn,
    input  logic [16:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_rd,
    input  logic        bus_wr,
    output logic        bus_ready,
    output logic        bus_rdata_ready,
    output logic [7:0]  bus_rdata
);

    localparam int                DEPTH     = 1 << MEM_AW;
    localparam logic [MEM_AW-1:0] LAST_ADDR = {MEM_AW{1'b1}};
    localparam logic [2:0]        LAT_LAST  = 3'(RD_LAT);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic [MEM_AW-1:0] r_init_cnt;
    logic [2:0]        r_lat;
    logic [7:0]        r_mem [DEPTH];
    logic [7:0]        r_mem_q;

    logic              w_init;
    logic              w_acc_wr;
    logic              w_acc_rd;
    logic              w_mem_we;
    logic [MEM_AW-1:0] w_mem_addr;
    logic [7:0]        w_mem_wdata;
    logic              w_unused_addr_hi;

    // A write wins over a simultaneous read; the read is simply dropped.
    assign w_init      = (r_state == ST_INIT);
    assign w_acc_wr    = bus_ready & bus_wr;
    assign w_acc_rd    = bus_ready & bus_rd & ~bus_wr;
    assign w_mem_we    = w_init | w_acc_wr;
    assign w_mem_addr  = w_init ? r_init_cnt : bus_addr[MEM_AW-1:0];
    assign w_mem_wdata = w_init ? (r_init_cnt[7:0] ^ INIT_SEED) : bus_wdata;

    generate
        if (MEM_AW < 17) begin : g_addr_hi
            assign w_unused_addr_hi = ^bus_addr[16:MEM_AW];
        end else begin : g_addr_full
            assign w_unused_addr_hi = 1'b0;
        end
    endgenerate

    // Single port: the read is captured at the accept edge; no write can land
    // during RD_WAIT because bus_ready is low, so r_mem_q stays current.
    always_ff @(posedge bus_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
        if (w_acc_rd) begin
            r_mem_q <= r_mem[w_mem_addr];
        end
    end

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= ST_INIT;
            r_init_cnt      <= '0;
            r_lat           <= 3'd0;
            bus_ready       <= 1'b0;
            bus_rdata_ready <= 1'b0;
            bus_rdata       <= 8'h00;
        end else begin
            bus_rdata_ready <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == LAST_ADDR) begin
                        r_state   <= ST_IDLE;
                        bus_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_acc_rd) begin
                        r_state   <= ST_RD_WAIT;
                        bus_ready <= 1'b0;
                        r_lat     <= 3'd1;
                    end
                end
                ST_RD_WAIT: begin
                    // r_lat counts edges since acceptance; the last one fires the strobe.
                    if (r_lat == LAT_LAST) begin
                        bus_rdata       <= r_mem_q;
                        bus_rdata_ready <= 1'b1;
                        bus_ready       <= 1'b1;
                        r_state         <= ST_IDLE;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                default: begin
                    r_state    <= ST_INIT;
                    r_init_cnt <= '0;
                    bus_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_bus_serv.sv
// Randomised bench for dma_bus_serv against a byte-array model of the memory.
module tb_dma_bus_serv;

    localparam int         MEM_AW = 12;
    localparam int         RD_LAT = 2;
    localparam int         DEPTH  = 1 << MEM_AW;
    localparam logic [7:0] SEED   = 8'h00;

    logic        bus_clk   = 1'b0;
    logic        rstn      = 1'b0;
    logic [16:0] bus_addr  = 17'h0;
    logic [7:0]  bus_wdata = 8'h00;
    logic        bus_rd    = 1'b0;
    logic        bus_wr    = 1'b0;
    logic        bus_ready;
    logic        bus_rdata_ready;
    logic [7:0]  bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_mem [DEPTH];

    dma_bus_serv #(
        .MEM_AW    (MEM_AW),
        .RD_LAT    (RD_LAT),
        .INIT_SEED (SEED)
    ) dut (
        .bus_clk         (bus_clk),
        .rstn            (rstn),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_rd          (bus_rd),
        .bus_wr          (bus_wr),
        .bus_ready       (bus_ready),
        .bus_rdata_ready (bus_rdata_ready),
        .bus_rdata       (bus_rdata)
    );

    always #5 bus_clk = ~bus_clk;

    // ---------------- reference model ----------------
    function automatic int model_idx(input logic [16:0] a);
        return int'(a) % DEPTH;
    endfunction

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = 8'(i) ^ SEED;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_write(input logic [16:0] addr, input logic [7:0] data);
        @(negedge bus_clk);
        bus_addr  = addr;
        bus_wdata = data;
        bus_wr    = 1'b1;
        bus_rd    = 1'b0;
        @(posedge bus_clk);
        #1;
        bus_wr = 1'b0;
        exp_mem[model_idx(addr)] = data;
    endtask

    // Returns the data seen with the strobe, edges from acceptance to strobe
    // (-1 if none within budget) and cycles bus_ready was low meanwhile.
    task automatic do_read(input logic [16:0] addr, output logic [7:0] data,
                           output int lat, output int ready_low);
        int k;
        @(negedge bus_clk);
        bus_addr = addr;
        bus_rd   = 1'b1;
        bus_wr   = 1'b0;
        @(posedge bus_clk);
        #1;
        bus_rd    = 1'b0;
        lat       = -1;
        data      = 8'h00;
        ready_low = 0;
        k         = 0;
        while (lat < 0 && k <= 20) begin
            if (bus_rdata_ready === 1'b1) begin
                lat  = k;
                data = bus_rdata;
            end else begin
                if (bus_ready !== 1'b1) ready_low++;
                @(posedge bus_clk);
                #1;
                k++;
            end
        end
    endtask

    task automatic wait_ready(output int edges, output int strobes);
        edges   = 0;
        strobes = 0;
        while (bus_ready !== 1'b1 && edges < 6000) begin
            @(posedge bus_clk);
            #1;
            edges++;
            if (bus_rdata_ready === 1'b1) strobes++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge bus_clk);
        #1;
        n_tests++;
        if (bus_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus_ready); end
        n_tests++;
        if (bus_rdata_ready !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", bus_rdata_ready); end
        n_tests++;
        if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", bus_rdata); end
    endtask

    task automatic test_init();
        int e, s, lat, rl;
        logic [7:0] d;
        @(negedge bus_clk);
        rstn = 1'b1;
        model_init();
        wait_ready(e, s);
        n_tests++;
        if (e !== DEPTH) begin n_fail++; $display("FAIL init_ready_cycles: got %0d expected %0d", e, DEPTH); end
        n_tests++;
        if (s !== 0) begin n_fail++; $display("FAIL init_no_strobe: got %0d strobes expected 0", s); end
        do_read(17'h000A5, d, lat, rl);
        n_tests++;
        if (d !== 8'hA5 || d !== exp_mem[model_idx(17'h000A5)]) begin
            n_fail++; $display("FAIL init_read_a5: got %h expected a5", d);
        end
        n_tests++;
        if (lat !== RD_LAT) begin n_fail++; $display("FAIL init_read_latency: got %0d expected %0d", lat, RD_LAT); end
        @(posedge bus_clk);
        #1;
        n_tests++;
        if (bus_rdata_ready !== 1'b0) begin n_fail++; $display("FAIL strobe_width: got %b expected 0", bus_rdata_ready); end
        n_tests++;
        if (bus_rdata !== 8'hA5) begin n_fail++; $display("FAIL rdata_hold: got %h expected a5", bus_rdata); end
    endtask

    task automatic test_ignored();
        int k, lat, rl;
        logic got;
        logic [7:0] d;
        @(negedge bus_clk);
        bus_addr = 17'h00030;
        bus_rd   = 1'b1;
        @(posedge bus_clk);
        #1;
        bus_rd    = 1'b0;
        bus_wr    = 1'b1;
        bus_addr  = 17'h00020;
        bus_wdata = 8'h11;
        k   = 0;
        got = 1'b0;
        d   = 8'h00;
        while (!got && k < 20) begin
            if (bus_rdata_ready === 1'b1) begin
                got = 1'b1;
                d   = bus_rdata;
            end else begin
                @(posedge bus_clk);
                #1;
                k++;
            end
        end
        bus_wr = 1'b0;
        n_tests++;
        if (got !== 1'b1 || k !== RD_LAT) begin n_fail++; $display("FAIL ignored_read_strobe: got latency %0d expected %0d", k, RD_LAT); end
        n_tests++;
        if (d !== exp_mem[model_idx(17'h00030)]) begin n_fail++; $display("FAIL ignored_read_data: got %h expected %h", d, exp_mem[model_idx(17'h00030)]); end
        do_read(17'h00020, d, lat, rl);
        n_tests++;
        if (d !== 8'h20) begin n_fail++; $display("FAIL ignored_write_kept: got %h expected 20", d); end
    endtask

    task automatic test_block();
        int lat, rl;
        logic [7:0] d;
        for (int a = 0; a < 1024; a++) begin
            do_write(17'(a), 8'(a) ^ 8'h5A);
        end
        for (int a = 0; a < 1024; a++) begin
            do_read(17'(a), d, lat, rl);
            n_tests++;
            if (d !== (8'(a) ^ 8'h5A)) begin n_fail++; $display("FAIL block_data addr=%0h: got %h expected %h", a, d, 8'(a) ^ 8'h5A); end
            n_tests++;
            if (lat !== RD_LAT) begin n_fail++; $display("FAIL block_latency addr=%0h: got %0d expected %0d", a, lat, RD_LAT); end
            n_tests++;
            if (rl !== RD_LAT) begin n_fail++; $display("FAIL block_ready_low addr=%0h: got %0d expected %0d", a, rl, RD_LAT); end
        end
    endtask

    task automatic test_simul();
        int strobes, drops, lat, rl;
        logic [7:0] d;
        @(negedge bus_clk);
        bus_addr  = 17'h00010;
        bus_wdata = 8'h3C;
        bus_rd    = 1'b1;
        bus_wr    = 1'b1;
        @(posedge bus_clk);
        #1;
        bus_rd = 1'b0;
        bus_wr = 1'b0;
        exp_mem[model_idx(17'h00010)] = 8'h3C;
        strobes = 0;
        drops   = 0;
        for (int i = 0; i < 2 * RD_LAT + 2; i++) begin
            if (bus_rdata_ready === 1'b1) strobes++;
            if (bus_ready !== 1'b1) drops++;
            @(posedge bus_clk);
            #1;
        end
        n_tests++;
        if (strobes !== 0) begin n_fail++; $display("FAIL simul_no_strobe: got %0d strobes expected 0", strobes); end
        n_tests++;
        if (drops !== 0) begin n_fail++; $display("FAIL simul_ready_kept: got %0d low cycles expected 0", drops); end
        do_read(17'h00010, d, lat, rl);
        n_tests++;
        if (d !== 8'h3C) begin n_fail++; $display("FAIL simul_write_data: got %h expected 3c", d); end
    endtask

    task automatic test_alias();
        logic [16:0] wa [3];
        logic [16:0] ra [3];
        logic [7:0]  wd [3];
        logic [7:0]  d;
        int lat, rl;
        wa = '{17'h10010, 17'h01005, 17'h1FFFF};
        ra = '{17'h00010, 17'h00005, 17'h00FFF};
        wd = '{8'hEE, 8'hC3, 8'h9D};
        for (int i = 0; i < 3; i++) do_write(wa[i], wd[i]);
        for (int i = 0; i < 3; i++) begin
            do_read(ra[i], d, lat, rl);
            n_tests++;
            if (d !== wd[i] || d !== exp_mem[model_idx(ra[i])]) begin
                n_fail++; $display("FAIL alias addr=%0h: got %h expected %h", ra[i], d, wd[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] hist[$];
        logic [16:0] a;
        logic [7:0]  d;
        int lat, rl;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = 17'($urandom_range(0, 17'h1FFFF));
                do_write(a, 8'($urandom_range(0, 255)));
                hist.push_back(a);
                if (hist.size() > 8) void'(hist.pop_front());
            end else begin
                if (hist.size() > 0 && $urandom_range(0, 1) == 1)
                    a = hist[$urandom_range(0, hist.size() - 1)] ^ 17'h10000;
                else
                    a = 17'($urandom_range(0, 17'h1FFFF));
                do_read(a, d, lat, rl);
                n_tests++;
                if (d !== exp_mem[model_idx(a)] || lat !== RD_LAT) begin
                    n_fail++;
                    $display("FAIL random_read addr=%0h: got %h lat %0d expected %h lat %0d",
                             a, d, lat, exp_mem[model_idx(a)], RD_LAT);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int e, s, lat, rl;
        logic [7:0] d;
        do_write(17'h00005, 8'h77);
        @(negedge bus_clk);
        bus_addr = 17'h00005;
        bus_rd   = 1'b1;
        @(posedge bus_clk);
        #1;
        bus_rd = 1'b0;
        @(posedge bus_clk);
        #1;
        rstn = 1'b0;
        #1;
        n_tests++;
        if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL midreset_rdata: got %h expected 00", bus_rdata); end
        n_tests++;
        if (bus_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b expected 0", bus_ready); end
        s = 0;
        repeat (3) begin
            @(posedge bus_clk);
            #1;
            if (bus_rdata_ready === 1'b1) s++;
        end
        @(negedge bus_clk);
        rstn = 1'b1;
        model_init();
        wait_ready(e, lat);
        s += lat;
        n_tests++;
        if (s !== 0) begin n_fail++; $display("FAIL midreset_no_strobe: got %0d strobes expected 0", s); end
        n_tests++;
        if (e !== DEPTH) begin n_fail++; $display("FAIL midreset_init_cycles: got %0d expected %0d", e, DEPTH); end
        do_read(17'h00005, d, lat, rl);
        n_tests++;
        if (d !== 8'h05 || d !== exp_mem[5]) begin n_fail++; $display("FAIL midreset_reinit: got %h expected 05", d); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_ignored();
        test_block();
        test_simul();
        test_alias();
        test_random();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
